// File: rtl/multi_ch_clk_div.sv
// multi_ch_clk_div: N-channel programmable clock divider.
// Each channel divides clk by 2*H (H = half-period in clk cycles).
// The channel outputs a 50% square wave and a one-cycle tick on each
// rising edge of that wave. New half-periods are staged in a shadow
// register and applied at the next terminal count, so no runt pulses
// occur. A global sync pulse restarts every channel in phase.
module multi_ch_clk_div #(
    parameter int N_CH       = 4,
    parameter int CNT_W      = 26,
    parameter int CH_W       = 2,
    parameter int RESET_HALF = 25000000
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              wr_en,
    input  logic [CH_W-1:0]   wr_ch,
    input  logic [CNT_W-1:0]  wr_half,
    input  logic [N_CH-1:0]   ch_en,
    input  logic              sync,
    output logic [N_CH-1:0]   sq_out,
    output logic [N_CH-1:0]   tick,
    output logic [N_CH-1:0]   pending
);

    localparam logic [CNT_W-1:0] RESET_HALF_C = CNT_W'(RESET_HALF);
    localparam logic [CNT_W-1:0] ZERO_C       = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] ONE_C        = {{(CNT_W-1){1'b0}}, 1'b1};

    // Per-channel state
    logic [CNT_W-1:0] cnt_r    [N_CH];
    logic [CNT_W-1:0] active_r [N_CH];
    logic [CNT_W-1:0] shadow_r [N_CH];
    logic [N_CH-1:0]  pend_r;
    logic [N_CH-1:0]  sq_r;
    logic [N_CH-1:0]  tick_r;

    // Next-state values
    logic [CNT_W-1:0] cnt_s    [N_CH];
    logic [CNT_W-1:0] active_s [N_CH];
    logic [CNT_W-1:0] shadow_s [N_CH];
    logic [N_CH-1:0]  pend_s;
    logic [N_CH-1:0]  sq_s;
    logic [N_CH-1:0]  tick_s;

    // Per-channel decode
    logic [N_CH-1:0]  wr_hit_s;
    logic [N_CH-1:0]  run_s;
    logic [N_CH-1:0]  tc_s;
    logic [CNT_W-1:0] reload_s [N_CH];

    // Decode write address, run condition, terminal count and reload source.
    // A channel index beyond N_CH-1 never matches, so such writes are dropped.
    always_comb begin
        for (int i = 0; i < N_CH; i++) begin
            wr_hit_s[i] = wr_en && (wr_ch == CH_W'(i));
            run_s[i]    = ch_en[i] && (active_r[i] != ZERO_C);
            tc_s[i]     = run_s[i] && (cnt_r[i] == (active_r[i] - ONE_C));
            // A same-cycle write beats an older shadow value.
            if (wr_hit_s[i]) begin
                reload_s[i] = wr_half;
            end else if (pend_r[i]) begin
                reload_s[i] = shadow_r[i];
            end else begin
                reload_s[i] = active_r[i];
            end
        end
    end

    // Next-state logic: sync > stopped > terminal count > normal count.
    always_comb begin
        for (int i = 0; i < N_CH; i++) begin
            cnt_s[i]    = cnt_r[i];
            active_s[i] = active_r[i];
            shadow_s[i] = shadow_r[i];
            pend_s[i]   = pend_r[i];
            sq_s[i]     = sq_r[i];
            tick_s[i]   = 1'b0;
            if (sync) begin
                cnt_s[i]    = ZERO_C;
                sq_s[i]     = 1'b0;
                active_s[i] = reload_s[i];
                pend_s[i]   = 1'b0;
            end else if (!run_s[i]) begin
                // Stopped: hold the counter at zero, output low.
                cnt_s[i] = ZERO_C;
                sq_s[i]  = 1'b0;
                if (wr_hit_s[i]) begin
                    active_s[i] = wr_half;
                    pend_s[i]   = 1'b0;
                end else begin
                    active_s[i] = active_r[i];
                end
            end else if (tc_s[i]) begin
                cnt_s[i]    = ZERO_C;
                active_s[i] = reload_s[i];
                pend_s[i]   = 1'b0;
                // Reloading zero stops the channel with the output low.
                if (reload_s[i] == ZERO_C) begin
                    sq_s[i]   = 1'b0;
                    tick_s[i] = 1'b0;
                end else begin
                    sq_s[i]   = ~sq_r[i];
                    tick_s[i] = ~sq_r[i];
                end
            end else begin
                cnt_s[i] = cnt_r[i] + ONE_C;
                // Mid-period write is staged until the period ends.
                if (wr_hit_s[i]) begin
                    shadow_s[i] = wr_half;
                    pend_s[i]   = 1'b1;
                end else begin
                    shadow_s[i] = shadow_r[i];
                end
            end
        end
    end

    // State and output registers with asynchronous reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < N_CH; i++) begin
                cnt_r[i]    <= ZERO_C;
                active_r[i] <= RESET_HALF_C;
                shadow_r[i] <= RESET_HALF_C;
            end
            pend_r <= {N_CH{1'b0}};
            sq_r   <= {N_CH{1'b0}};
            tick_r <= {N_CH{1'b0}};
        end else begin
            for (int i = 0; i < N_CH; i++) begin
                cnt_r[i]    <= cnt_s[i];
                active_r[i] <= active_s[i];
                shadow_r[i] <= shadow_s[i];
            end
            pend_r <= pend_s;
            sq_r   <= sq_s;
            tick_r <= tick_s;
        end
    end

    assign sq_out  = sq_r;
    assign tick    = tick_r;
    assign pending = pend_r;

endmodule

// File: tb/tb_multi_ch_clk_div.sv
// Testbench for multi_ch_clk_div: directed scenarios with literal
// expectations plus randomized traffic, all checked every cycle against
// a countdown-based behavioural model of each channel.
module tb_multi_ch_clk_div;

    localparam int N_CH  = 4;
    localparam int CNT_W = 8;
    localparam int CH_W  = 3;
    localparam int RH    = 3;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             wr_en = 1'b0;
    logic [CH_W-1:0]  wr_ch = '0;
    logic [CNT_W-1:0] wr_half = '0;
    logic [N_CH-1:0]  ch_en = '0;
    logic             sync = 1'b0;
    logic [N_CH-1:0]  sq_out, tick, pending;

    int n_chk  = 0;
    int n_fail = 0;

    multi_ch_clk_div #(.N_CH(N_CH), .CNT_W(CNT_W), .CH_W(CH_W), .RESET_HALF(RH)) dut (
        .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_ch(wr_ch), .wr_half(wr_half),
        .ch_en(ch_en), .sync(sync), .sq_out(sq_out), .tick(tick), .pending(pending)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Behavioural model: each channel counts down the cycles left in the
    // current half-period; the level flips when that reaches zero.
    int m_act [N_CH];
    int m_sh  [N_CH];
    int m_rem [N_CH];
    bit m_pend [N_CH];
    bit m_lvl  [N_CH];
    bit m_tk   [N_CH];

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < N_CH; i++) begin
                m_act[i] = RH; m_sh[i] = RH; m_rem[i] = RH;
                m_pend[i] = 0; m_lvl[i] = 0; m_tk[i] = 0;
            end
        end else begin
            for (int i = 0; i < N_CH; i++) begin
                bit wh;
                int nv;
                wh = wr_en && (int'(wr_ch) == i);
                m_tk[i] = 0;
                if (sync) begin
                    m_act[i] = wh ? int'(wr_half) : (m_pend[i] ? m_sh[i] : m_act[i]);
                    m_pend[i] = 0; m_lvl[i] = 0; m_rem[i] = m_act[i];
                end else if (!(ch_en[i] && m_act[i] != 0)) begin
                    m_lvl[i] = 0;
                    if (wh) begin
                        m_act[i] = int'(wr_half);
                        m_pend[i] = 0;
                    end
                    m_rem[i] = m_act[i];
                end else begin
                    m_rem[i] = m_rem[i] - 1;
                    if (m_rem[i] == 0) begin
                        nv = wh ? int'(wr_half) : (m_pend[i] ? m_sh[i] : m_act[i]);
                        m_act[i] = nv; m_pend[i] = 0; m_rem[i] = nv;
                        if (nv == 0) begin
                            m_lvl[i] = 0;
                        end else begin
                            m_tk[i] = !m_lvl[i];
                            m_lvl[i] = !m_lvl[i];
                        end
                    end else if (wh) begin
                        m_sh[i] = int'(wr_half);
                        m_pend[i] = 1;
                    end
                end
            end
        end
    end

    // Compare DUT against the model on every falling edge.
    always @(negedge clk) begin
        logic [N_CH-1:0] e_sq, e_tk, e_pd;
        for (int i = 0; i < N_CH; i++) begin
            e_sq[i] = m_lvl[i]; e_tk[i] = m_tk[i]; e_pd[i] = m_pend[i];
        end
        chk("model_sq", 32'(sq_out), 32'(e_sq));
        chk("model_tick", 32'(tick), 32'(e_tk));
        chk("model_pending", 32'(pending), 32'(e_pd));
    end

    task automatic wr(input int ch, input int h);
        wr_en = 1'b1; wr_ch = CH_W'(ch); wr_half = CNT_W'(h);
        @(negedge clk);
        wr_en = 1'b0;
    endtask

    initial begin
        logic [10:1] e_sq10;
        logic [10:1] e_tk10;
        e_sq10 = 10'b1100011100;
        e_tk10 = 10'b0100000100;

        // Reset state and first periods with H = 3
        repeat (2) @(negedge clk);
        chk("reset_sq", 32'(sq_out), 32'd0);
        chk("reset_pending", 32'(pending), 32'd0);
        rst_n = 1'b1; ch_en = 4'b0001;
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk);
            chk("boot_sq0", 32'(sq_out[0]), 32'(e_sq10[k]));
            chk("boot_tick0", 32'(tick[0]), 32'(e_tk10[k]));
        end
        chk("boot_others", 32'(sq_out[3:1]), 32'd0);

        // Sync-aligned ch0 at H = 4, then staged change to H = 2 at cnt = 1
        sync = 1'b1; wr_en = 1'b1; wr_ch = 3'd0; wr_half = 8'd4;
        @(negedge clk);
        sync = 1'b0; wr_en = 1'b0;
        @(negedge clk);
        wr(0, 2);
        chk("stage_pend_a", 32'(pending[0]), 32'd1);
        @(negedge clk);
        chk("stage_pend_b", 32'(pending[0]), 32'd1);
        chk("stage_sq_low", 32'(sq_out[0]), 32'd0);
        @(negedge clk);
        chk("stage_pend_clr", 32'(pending[0]), 32'd0);
        chk("stage_rise", 32'(sq_out[0]), 32'd1);
        @(negedge clk);
        chk("stage_hold", 32'(sq_out[0]), 32'd1);
        @(negedge clk);
        chk("stage_fall_h2", 32'(sq_out[0]), 32'd0);

        // Stopped ch1: write H = 5, then enable
        wr(1, 5);
        ch_en = 4'b0011;
        for (int k = 1; k <= 5; k++) begin
            @(negedge clk);
            chk("enable_rise1", 32'(sq_out[1]), (k == 5) ? 32'd1 : 32'd0);
        end

        // Global sync re-aligns ch0 (H=3) and ch1 (H=7)
        wr(0, 3);
        wr(1, 7);
        repeat ($urandom_range(1, 9)) @(negedge clk);
        sync = 1'b1;
        @(negedge clk);
        sync = 1'b0;
        chk("sync_low", 32'(sq_out[1:0]), 32'd0);
        for (int k = 1; k <= 7; k++) begin
            @(negedge clk);
            if (k == 3) chk("sync_tick0", 32'(tick[0]), 32'd1);
            if (k == 7) chk("sync_tick1", 32'(tick[1]), 32'd1);
        end

        // H = 0 stops ch2 after its current half-period; H = 1 divides by two
        ch_en = 4'b0111;
        repeat (2) @(negedge clk);
        wr(2, 0);
        repeat (8) @(negedge clk);
        chk("stop_sq2", 32'(sq_out[2]), 32'd0);
        wr(2, 1);
        @(negedge clk);
        chk("div2_a", 32'(sq_out[2]), 32'd1);
        @(negedge clk);
        chk("div2_b", 32'(sq_out[2]), 32'd0);
        @(negedge clk);
        chk("div2_c", 32'(sq_out[2]), 32'd1);

        // Asynchronous reset mid-period, then RESET_HALF restored
        #2 rst_n = 1'b0;
        #1;
        chk("areset_sq", 32'(sq_out), 32'd0);
        chk("areset_tick", 32'(tick), 32'd0);
        chk("areset_pend", 32'(pending), 32'd0);
        @(negedge clk);
        ch_en = 4'b0001; rst_n = 1'b1;
        for (int k = 1; k <= 3; k++) begin
            @(negedge clk);
            chk("post_reset_sq0", 32'(sq_out[0]), (k == 3) ? 32'd1 : 32'd0);
        end
        // Out-of-range channel write is ignored
        wr(5, 9);
        chk("bad_ch_pend", 32'(pending), 32'd0);

        // Randomized traffic against the model
        for (int c = 0; c < 3000; c++) begin
            wr_en   = ($urandom_range(0, 5) == 0);
            wr_ch   = CH_W'($urandom_range(0, 7));
            wr_half = CNT_W'($urandom_range(0, 6));
            sync    = ($urandom_range(0, 60) == 0);
            if ($urandom_range(0, 40) == 0) ch_en = N_CH'($urandom);
            @(negedge clk);
        end
        wr_en = 1'b0; sync = 1'b0;
        @(negedge clk);

        $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
        $finish;
    end

endmodule

// File: doc/multi_ch_clk_div.md
Name: multi_ch_clk_div

Overview:
- N-channel programmable clock divider. Successor to the single-output divider used for the clock/time-set logic.
- Each channel produces a 50% square wave and a one-cycle rising-edge tick from the system clock.
- Each channel takes a precomputed half-period count. No runtime division.
- Adds per-channel enable, glitch-free shadowed reload, a stop code and a global phase sync.

Parameters:
N_CH, 4, number of independent divider channels (1..16)
CNT_W, 26, width of the half-period count and the internal counter
CH_W, 2, width of the channel-select field; must satisfy 2^CH_W >= N_CH
RESET_HALF, 25000000, half-period loaded into every channel at reset (1 Hz from 50 MHz)

Ports:
clk  in  1  system clock; all logic on its rising edge
rst_n  in  1  asynchronous, active-low reset
wr_en  in  1  one-cycle write strobe for a half-period value
wr_ch  in  CH_W  channel addressed by the write
wr_half  in  CNT_W  new half-period H, in clk cycles; 0 = stop
ch_en  in  N_CH  per-channel run enable, level-sensitive
sync  in  1  one-cycle global restart, aligns all channels
sq_out  out  N_CH  registered square outputs
tick  out  N_CH  registered one-cycle pulse, coincident with each sq_out rising edge
pending  out  N_CH  1 = a shadowed value is waiting for the next terminal count

Behaviour:
- Per-channel state:
  - cnt[CNT_W]: counter.
  - active[CNT_W]: half-period in use.
  - shadow[CNT_W]: staged half-period.
  - pend: reload-waiting flag.
  - sq: square-output register.
- Reset (rst_n low, asynchronous):
  - cnt = 0, sq_out = 0, tick = 0, pending = 0.
  - active = shadow = RESET_HALF.
  - Reset asserted mid-period aborts immediately; no partial period completes.
- Run condition: ch_en[i] = 1 and active != 0.
  - Each cycle, cnt increments.
  - Terminal count is cnt == active - 1. On terminal count: cnt <= 0 and sq toggles.
  - Output period = 2*active cycles. H = 1 gives clk/2.
- tick[i] = 1 for exactly one cycle, in the same cycle sq_out[i] goes 0 -> 1. tick is 0 on the falling toggle.
- Stopped (ch_en[i] = 0, or active = 0):
  - cnt held at 0, sq_out[i] = 0, tick[i] = 0.
  - After re-enable with active = H, the first rising edge of sq_out occurs H cycles later.
- Write, running channel (wr_en = 1, wr_ch = i < N_CH):
  - shadow <= wr_half, pend <= 1. active is unchanged.
  - At the next terminal count: active <= shadow, pend <= 0.
  - The current half-period always completes at the old length, so no runt pulses occur.
- Write, stopped channel: active <= wr_half immediately, cnt <= 0, pend stays 0.
- Write on the same cycle as that channel's terminal count: wr_half is loaded directly into active. Any older shadow is discarded and pend <= 0.
- Multiple writes before a terminal count: last write wins.
- Write with wr_ch >= N_CH: ignored with no state change.
- sync = 1, applied to all channels in one cycle:
  - cnt <= 0, sq <= 0, tick <= 0.
  - A pending shadow is applied to active immediately; pend <= 0.
  - A write in the same cycle is applied directly to active; it has priority over shadow.
  - sync has priority over terminal count.
- Reloading to H = 0: the channel enters the stopped state at that reload, with sq_out forced to 0.
- Latency:
  - Outputs are registered; no combinational path from inputs to outputs.
  - pending rises the cycle after wr_en.
  - For a running channel with H = h written while cnt = 0 and sq = 0, sq_out rises h cycles after reload.

Test Plan:
- Reset release, ch_en = 4'b0001, RESET_HALF overridden to 3 -> sq_out[0] rises at cycle 3, falls at 6, rises at 9; tick[0] high only at cycles 3 and 9; channels 1..3 stay 0.
- Ch0 running H = 4, write H = 2 at cnt = 1 -> pending[0] = 1 until that half-period ends at the old length (4 cycles); then half-periods are 2 cycles and pending[0] = 0.
- Ch1 disabled, write H = 5, enable -> first sq_out[1] rise exactly 5 cycles after enable; pending[1] never asserts.
- Ch0 H = 3, ch1 H = 7 running at arbitrary phases, pulse sync -> both sq_out = 0 next cycle; rises at +3 and +7 cycles, with tick[0] and tick[1] re-aligned.
- Write H = 0 to running ch2 -> after the current half-period, sq_out[2] = 0 permanently, tick[2] = 0; then write H = 1 -> toggles every cycle.
- wr_ch = 5 with N_CH = 4 -> no change to any channel. Assert rst_n low mid-period -> all outputs 0 immediately, active = RESET_HALF after release.
